// File: rtl/fpu_round_pkg.sv
// Shared definitions for the floating-point rounding datapath.
//   - round-type encodings used by the rounding-decision block
//   - fraction/exponent widths for single and double precision
//   - exp_all_ones(): all-ones biased exponent (Inf/NaN) for a given width
package fpu_round_pkg;

  typedef enum logic [1:0] {
    RND_TOWARD_ZERO = 2'b00,
    RND_TOWARD_NEG  = 2'b01,
    RND_TOWARD_POS  = 2'b10
  } round_type_e;

  localparam int SP_W  = 23;
  localparam int SP_EW = 8;
  localparam int DP_W  = 52;
  localparam int DP_EW = 11;

  function automatic logic [63:0] exp_all_ones(input int ew);
    return (64'd1 << ew) - 64'd1;
  endfunction

endpackage

// File: rtl/round_pipe_reg.sv
// Generic valid/ready pipeline register.
//   in_valid/in_ready/in_data   : upstream handshake and payload
//   out_valid/out_ready/out_data: downstream handshake and payload
// The register accepts a new beat whenever it is empty or its current beat is
// leaving, so a chain of these sustains one beat per cycle. While stalled the
// stored payload is held untouched.
module round_pipe_reg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q,  data_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/round_sgf_inc.sv
// Rounding-increment stage of the add/subtract datapath.
// Adds one ulp to the truncated fraction when the round flag is set,
// renormalises on carry-out and flags exponent overflow to infinity.
// Inf/NaN inputs (all-ones exponent) pass through untouched.
// Two-stage valid/ready pipeline, latency 2, throughput 1 beat/cycle.
//   clk, rst (async, active-high)
//   in_valid/in_ready, sgf_i, exp_i, sign_i, round_flag_i : input beat
//   out_valid/out_ready, sgf_o, exp_o, sign_o, overflow_o : result beat
// Optional build macro ROUND_SGF_INC_CNT_EN adds saturating counters
//   inc_cnt_o (emitted beats with an applied increment) and
//   ovf_cnt_o (emitted beats that overflowed).
module round_sgf_inc
  import fpu_round_pkg::*;
#(
  parameter int W  = 23,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  sgf_i,
  input  logic [EW-1:0] exp_i,
  input  logic          sign_i,
  input  logic          round_flag_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  sgf_o,
  output logic [EW-1:0] exp_o,
  output logic          sign_o,
  output logic          overflow_o
`ifdef ROUND_SGF_INC_CNT_EN
  ,
  output logic [15:0]   inc_cnt_o,
  output logic [15:0]   ovf_cnt_o
`endif
);

  localparam logic [EW-1:0] EXP_MAX = EW'(exp_all_ones(EW));

`ifdef ROUND_SGF_INC_CNT_EN
  localparam int PW1 = W + EW + 4;
  localparam int PW2 = W + EW + 3;
`else
  localparam int PW1 = W + EW + 3;
  localparam int PW2 = W + EW + 2;
`endif

  logic           pt_s1, inc_s1;
  logic [W:0]     sum_s1;
  logic [PW1-1:0] s1_din, s1_dout;
  logic           s1_valid, s2_ready;

  logic [W:0]     s1_sum;
  logic [EW-1:0]  s1_exp, exp_inc;
  logic           s1_sign, s1_pt;
  logic [W-1:0]   r_sgf;
  logic [EW-1:0]  r_exp;
  logic           r_ovf;
  logic [PW2-1:0] s2_din, s2_dout;

  // Stage 1: increment. Inf/NaN beats ignore the round flag.
  always_comb begin
    pt_s1  = (exp_i == EXP_MAX);
    inc_s1 = round_flag_i & ~pt_s1;
    sum_s1 = {1'b0, sgf_i} + {{W{1'b0}}, inc_s1};
  end

`ifdef ROUND_SGF_INC_CNT_EN
  assign s1_din = {inc_s1, pt_s1, sign_i, exp_i, sum_s1};
`else
  assign s1_din = {pt_s1, sign_i, exp_i, sum_s1};
`endif

  round_pipe_reg #(.PW(PW1)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_din),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_dout)
  );

  // Stage 2: renormalise. A carry out of the fraction means it was all-ones:
  // the fraction wraps to zero and the exponent bumps, which also promotes a
  // denormal (exp 0) to the smallest normal. Reaching the all-ones exponent
  // yields infinity.
  assign s1_sum  = s1_dout[W:0];
  assign s1_exp  = s1_dout[W+EW:W+1];
  assign s1_sign = s1_dout[W+EW+1];
  assign s1_pt   = s1_dout[W+EW+2];
  assign exp_inc = s1_exp + {{(EW-1){1'b0}}, 1'b1};

  always_comb begin
    r_sgf = s1_sum[W-1:0];
    r_exp = s1_exp;
    r_ovf = 1'b0;
    if (!s1_pt && s1_sum[W]) begin
      r_sgf = '0;
      r_exp = exp_inc;
      r_ovf = (exp_inc == EXP_MAX);
    end
  end

`ifdef ROUND_SGF_INC_CNT_EN
  assign s2_din = {s1_dout[W+EW+3], r_ovf, s1_sign, r_exp, r_sgf};
`else
  assign s2_din = {r_ovf, s1_sign, r_exp, r_sgf};
`endif

  round_pipe_reg #(.PW(PW2)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_dout)
  );

  assign sgf_o      = s2_dout[W-1:0];
  assign exp_o      = s2_dout[W+EW-1:W];
  assign sign_o     = s2_dout[W+EW];
  assign overflow_o = s2_dout[W+EW+1];

`ifdef ROUND_SGF_INC_CNT_EN
  logic [15:0] inc_cnt_q, inc_cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    inc_cnt_d = inc_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (out_valid && out_ready) begin
      if (s2_dout[W+EW+2] && inc_cnt_q != 16'hFFFF) inc_cnt_d = inc_cnt_q + 16'd1;
      if (overflow_o && ovf_cnt_q != 16'hFFFF)      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_cnt_q <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else begin
      inc_cnt_q <= inc_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign inc_cnt_o = inc_cnt_q;
  assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_round_sgf_inc.sv
module tb_round_sgf_inc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] sgf_i = '0;
  logic [7:0]  exp_i = '0;
  logic        sign_i = 1'b0;
  logic        round_flag_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [22:0] sgf_o;
  logic [7:0]  exp_o;
  logic        sign_o;
  logic        overflow_o;
`ifdef ROUND_SGF_INC_CNT_EN
  logic [15:0] inc_cnt_o, ovf_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;
  int exp_inc_cnt = 0;
  int exp_ovf_cnt = 0;

  always #5 clk = ~clk;

  round_sgf_inc #(.W(23), .EW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sgf_i       (sgf_i),
    .exp_i       (exp_i),
    .sign_i      (sign_i),
    .round_flag_i(round_flag_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sgf_o       (sgf_o),
    .exp_o       (exp_o),
    .sign_o      (sign_o),
    .overflow_o  (overflow_o)
`ifdef ROUND_SGF_INC_CNT_EN
    ,
    .inc_cnt_o   (inc_cnt_o),
    .ovf_cnt_o   (ovf_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Result of one beat from the arithmetic meaning of rounding:
  // {applied, overflow, sign, exp, sgf}
  function automatic logic [33:0] model(input logic [22:0] s, input logic [7:0] e,
                                        input logic sg, input logic f);
    int v, ee;
    logic ap, ov;
    logic [22:0] so;
    logic [7:0]  eo;
    ap = 1'b0; ov = 1'b0; so = s; eo = e;
    if (e != 8'hFF) begin
      ap = f;
      v  = int'(s) + (f ? 1 : 0);
      ee = int'(e);
      if (v == (1 << 23)) begin
        so = '0;
        ee = ee + 1;
        ov = (ee == 255);
      end else begin
        so = v[22:0];
      end
      eo = ee[7:0];
    end
    return {ap, ov, sg, eo, so};
  endfunction

  function automatic logic [32:0] dut_out();
    return {overflow_o, sign_o, exp_o, sgf_o};
  endfunction

  // Scoreboard: expected results queued on acceptance, popped on emission.
  logic [33:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [32:0] stall_val  = '0;

  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (stall_prev) chk("stall_hold", {31'd0, dut_out()}, {31'd0, stall_val});
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {31'd0, dut_out()}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            if (e[33]) exp_inc_cnt++;
            if (e[32]) exp_ovf_cnt++;
            chk("stream_out", {31'd0, dut_out()}, {31'd0, e[32:0]});
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = dut_out();
      if (in_valid && in_ready) exp_q.push_back(model(sgf_i, exp_i, sign_i, round_flag_i));
    end
  end

  task automatic send(input logic [22:0] s, input logic [7:0] e, input logic sg, input logic f);
    int n;
    logic ok;
    in_valid = 1'b1; sgf_i = s; exp_i = e; sign_i = sg; round_flag_i = f;
    n = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 100) begin
        chk("send_timeout", 64'd0, 64'd1);
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Single beat with an empty pipeline: pin the model, then check the DUT
  // two cycles after acceptance.
  task automatic run1(input string name, input logic [22:0] s, input logic [7:0] e,
                      input logic sg, input logic f, input logic [32:0] lit);
    logic [33:0] m;
    m = model(s, e, sg, f);
    chk({name, "_model"}, {31'd0, m[32:0]}, {31'd0, lit});
    send(s, e, sg, f);
    chk({name, "_early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({name, "_vld"}, {63'd0, out_valid}, 64'd1);
    chk(name, {31'd0, dut_out()}, {31'd0, lit});
    @(posedge clk); #1;
  endtask

  logic [22:0] s5 [5] = '{23'h000010, 23'h7FFFFF, 23'h000003, 23'h2AAAAA, 23'h7FFFFE};
  logic [7:0]  e5 [5] = '{8'h10,      8'h7F,      8'hFF,      8'h01,      8'hFE};
  logic        f5 [5] = '{1'b1,       1'b1,       1'b1,       1'b0,       1'b1};

  initial begin
    int pop0;
    logic saw_low;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs",   {31'd0, dut_out()}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    run1("case1", 23'h000001, 8'h80, 1'b0, 1'b1, {1'b0, 1'b0, 8'h80, 23'h000002});
    run1("case2", 23'h7FFFFF, 8'h80, 1'b0, 1'b1, {1'b0, 1'b0, 8'h81, 23'h000000});
    run1("case3", 23'h7FFFFF, 8'hFE, 1'b0, 1'b1, {1'b1, 1'b0, 8'hFF, 23'h000000});
    run1("case4", 23'h400000, 8'hFF, 1'b1, 1'b1, {1'b0, 1'b1, 8'hFF, 23'h400000});
    run1("zero",  23'h000000, 8'h00, 1'b1, 1'b1, {1'b0, 1'b1, 8'h00, 23'h000001});
    run1("denorm_promote", 23'h7FFFFF, 8'h00, 1'b0, 1'b1, {1'b0, 1'b0, 8'h01, 23'h000000});
    run1("no_flag", 23'h123456, 8'h40, 1'b1, 1'b0, {1'b0, 1'b1, 8'h40, 23'h123456});

    // Case 5: back-to-back stream with a 3-cycle output stall.
    pop0 = n_pop;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(s5[i], e5[i], i[0], f5[i]);
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        if (!out_valid) chk("case5_first_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("case5_in_ready_low", {63'd0, saw_low}, 64'd1);
    chk("case5_count", 64'(n_pop - pop0), 64'd5);
    chk("case5_drained", 64'(exp_q.size()), 64'd0);

    // Case 6: reset with two beats in flight.
    send(23'h000100, 8'h20, 1'b0, 1'b1);
    send(23'h000200, 8'h21, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("case6_rst_vld", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("case6_no_stale", {63'd0, out_valid}, 64'd0);
    end
    run1("case6_new", 23'h0ABCDE, 8'h33, 1'b1, 1'b1, {1'b0, 1'b1, 8'h33, 23'h0ABCDF});

`ifdef ROUND_SGF_INC_CNT_EN
    chk("inc_cnt", {48'd0, inc_cnt_o}, 64'(exp_inc_cnt));
    chk("ovf_cnt", {48'd0, ovf_cnt_o}, 64'(exp_ovf_cnt));
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
